// File: rtl/patp_pkg.sv
// Shared definitions for the PATP core: opcodes, ALU operations and
// sequencer state encoding.
package patp_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned INSN_W = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_STA  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier feeding the control_unit sequencer.
module opcode_decode
    import patp_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_jump,
    output logic       is_cond,
    output logic       is_halt,
    output logic [1:0] alu_op
);

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_jump  = 1'b0;
        is_cond  = 1'b0;
        is_halt  = 1'b0;
        alu_op   = ALU_PASS;
        case (opcode)
            OP_LDA:  is_mem = 1'b1;
            OP_STA:  begin is_mem = 1'b1; is_store = 1'b1; end
            OP_ADD:  begin is_mem = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin is_mem = 1'b1; alu_op = ALU_SUB; end
            OP_JMP:  is_jump = 1'b1;
            OP_JZ:   is_cond = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle PATP sequencer: fetch, decode, execute with req/ack memories,
// then write the next address back into the PC.
module control_unit
    import patp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc_addr,
    output logic                pc_we,
    output logic [ADDR_W-1:0]   pc_in,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [INSN_W-1:0]   imem_data,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    input  logic                dmem_ack,
    output logic [1:0]          alu_op,
    output logic                acc_we,
    input  logic                zero,
    output logic                halted
);

    state_t            state_q, state_d;
    logic [INSN_W-1:0] ir_q;
    logic              take_q;

    logic       is_mem, is_store, is_jump, is_cond, is_halt;
    logic [1:0] dec_alu;
    logic [ADDR_W-1:0] pc_next;

    opcode_decode u_dec (
        .opcode   (ir_q[7:5]),
        .is_mem   (is_mem),
        .is_store (is_store),
        .is_jump  (is_jump),
        .is_cond  (is_cond),
        .is_halt  (is_halt),
        .alu_op   (dec_alu)
    );

    assign pc_next = pc_addr + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_ack)
                ir_q <= imem_data;
            if (state_q == ST_EXEC && !is_mem)
                take_q <= zero;
        end
    end

    // Outputs are gated by rst_n so they drop asynchronously with reset.
    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        pc_in     = '0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_addr = '0;
        alu_op    = ALU_PASS;
        acc_we    = 1'b0;
        halted    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack)
                        state_d = ST_DECODE;
                end
                ST_DECODE: state_d = is_halt ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    if (is_mem) begin
                        dmem_req  = 1'b1;
                        dmem_we   = is_store;
                        dmem_addr = ir_q[4:0];
                        alu_op    = dec_alu;
                        acc_we    = dmem_ack & ~is_store;
                        if (dmem_ack)
                            state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pc_we   = 1'b1;
                    pc_in   = (is_jump || (is_cond && take_q)) ? ir_q[4:0] : pc_next;
                    state_d = ST_FETCH;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a PC register and zero/wait-state memories.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] pc;
    logic       pc_we;
    logic [4:0] pc_in;
    logic       imem_req, imem_ack;
    logic [7:0] imem_data;
    logic       dmem_req, dmem_we, dmem_ack;
    logic [4:0] dmem_addr;
    logic [1:0] alu_op;
    logic       acc_we;
    logic       zero = 1'b0;
    logic       halted;

    logic [7:0] prog [32];
    int         dmem_delay = 0;
    int         dcnt;
    int         checks = 0;
    int         errors = 0;

    control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_addr   (pc),
        .pc_we     (pc_we),
        .pc_in     (pc_in),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_ack  (dmem_ack),
        .alu_op    (alu_op),
        .acc_we    (acc_we),
        .zero      (zero),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= 5'd0;
        else if (pc_we) pc <= pc_in;
    end

    assign imem_ack  = imem_req;
    assign imem_data = prog[pc];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     dcnt <= 0;
        else if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else                            dcnt <= 0;
    end
    assign dmem_ack = dmem_req && (dcnt >= dmem_delay);

    task automatic load_prog(input logic [7:0] fill);
        for (int a = 0; a < 32; a++) prog[a] = fill;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc_we, pc_in, imem_req, dmem_req, dmem_we, dmem_addr, alu_op, acc_we, halted} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got pc_we=%b pc_in=%0d imem_req=%b dmem_req=%b halted=%b expected all 0",
                     pc_we, pc_in, imem_req, dmem_req, halted);
        end
    endtask

    task automatic test_nops();
        load_prog(8'h00);
        dmem_delay = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (imem_req !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL nop_imem_req cycle %0d got %b expected %b", i, imem_req, (i % 4 == 0));
            end
            checks++;
            if (pc_we !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL nop_pc_we cycle %0d got %b expected %b", i, pc_we, (i % 4 == 3));
            end
            if (i % 4 == 3) begin
                checks++;
                if (pc_in !== 5'(i / 4 + 1)) begin
                    errors++;
                    $display("FAIL nop_pc_in cycle %0d got %0d expected %0d", i, pc_in, i / 4 + 1);
                end
            end
            checks++;
            if ({dmem_req, acc_we, halted} !== 3'b000) begin
                errors++;
                $display("FAIL nop_strobes cycle %0d got dmem_req=%b acc_we=%b halted=%b expected 0",
                         i, dmem_req, acc_we, halted);
            end
        end
    endtask

    task automatic test_wrap();
        load_prog(8'h00);
        prog[0] = 8'hBF;    // JMP 31
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3 || i == 7) begin
                checks++;
                if (pc_we !== 1'b1 || pc_in !== ((i == 3) ? 5'd31 : 5'd0)) begin
                    errors++;
                    $display("FAIL wrap_pc cycle %0d got pc_we=%b pc_in=%0d expected 1/%0d",
                             i, pc_we, pc_in, (i == 3) ? 31 : 0);
                end
            end
        end
    endtask

    task automatic test_mem_ops();
        logic       e_req, e_we, e_acc, e_pcwe;
        logic [4:0] e_addr, e_pcin;
        logic [1:0] e_alu;
        load_prog(8'h00);
        prog[0] = 8'h25;    // LDA 5
        prog[1] = 8'h49;    // STA 9
        prog[2] = 8'h63;    // ADD 3
        prog[3] = 8'h84;    // SUB 4
        dmem_delay = 3;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 6) dmem_delay = 0;
            e_req = 0; e_we = 0; e_acc = 0; e_pcwe = 0; e_addr = 0; e_pcin = 0; e_alu = 0;
            case (i)
                2, 3, 4: begin e_req = 1; e_addr = 5; end
                5:  begin e_req = 1; e_addr = 5; e_acc = 1; end
                6:  begin e_pcwe = 1; e_pcin = 1; end
                9:  begin e_req = 1; e_we = 1; e_addr = 9; end
                10: begin e_pcwe = 1; e_pcin = 2; end
                13: begin e_req = 1; e_addr = 3; e_acc = 1; e_alu = 2'b01; end
                14: begin e_pcwe = 1; e_pcin = 3; end
                17: begin e_req = 1; e_addr = 4; e_acc = 1; e_alu = 2'b10; end
                18: begin e_pcwe = 1; e_pcin = 4; end
                default: ;
            endcase
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, acc_we, alu_op} !== {e_req, e_we, e_addr, e_acc, e_alu}) begin
                errors++;
                $display("FAIL mem_dmem cycle %0d got req=%b we=%b addr=%0d acc_we=%b alu=%0d expected req=%b we=%b addr=%0d acc_we=%b alu=%0d",
                         i, dmem_req, dmem_we, dmem_addr, acc_we, alu_op, e_req, e_we, e_addr, e_acc, e_alu);
            end
            checks++;
            if (pc_we !== e_pcwe || pc_in !== e_pcin) begin
                errors++;
                $display("FAIL mem_pc cycle %0d got pc_we=%b pc_in=%0d expected %b/%0d",
                         i, pc_we, pc_in, e_pcwe, e_pcin);
            end
        end
    endtask

    task automatic test_branches();
        load_prog(8'h00);
        prog[0]  = 8'hB4;   // JMP 20
        prog[20] = 8'hC7;   // JZ 7 (taken)
        prog[7]  = 8'hA3;   // JMP 3
        prog[3]  = 8'hC7;   // JZ 7 (not taken)
        dmem_delay = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            zero = (i < 12);
            if (i % 4 == 3) begin
                checks++;
                if (pc_we !== 1'b1 || pc_in !== ((i == 3) ? 5'd20 : (i == 7) ? 5'd7 : (i == 11) ? 5'd3 : 5'd4)) begin
                    errors++;
                    $display("FAIL branch_pc cycle %0d got pc_we=%b pc_in=%0d expected 1/%0d",
                             i, pc_we, pc_in, (i == 3) ? 20 : (i == 7) ? 7 : (i == 11) ? 3 : 4);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_halt();
        load_prog(8'h00);
        prog[2] = 8'hE0;    // HALT
        do_reset();
        for (int i = 0; i < 62; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 9 || i >= 10) begin
                checks++;
                if (halted !== (i >= 10)) begin
                    errors++;
                    $display("FAIL halt_flag cycle %0d got %b expected %b", i, halted, (i >= 10));
                end
            end
            if (i >= 10) begin
                checks++;
                if ({pc_we, imem_req, dmem_req, acc_we} !== 4'b0000) begin
                    errors++;
                    $display("FAIL halt_quiet cycle %0d got pc_we=%b imem_req=%b dmem_req=%b acc_we=%b expected 0",
                             i, pc_we, imem_req, dmem_req, acc_we);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        load_prog(8'h00);
        prog[0] = 8'h25;    // LDA 5, stalled
        dmem_delay = 100;
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_req got %b expected 1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_we, imem_req, dmem_req, dmem_addr, acc_we, halted} !== 10'h0) begin
            errors++;
            $display("FAIL mid_async_clear got pc_we=%b imem_req=%b dmem_req=%b addr=%0d acc_we=%b expected 0",
                     pc_we, imem_req, dmem_req, dmem_addr, acc_we);
        end
        dmem_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart got imem_req=%b pc_we=%b expected 1/0", imem_req, pc_we);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pc_we !== 1'b1 || pc_in !== 5'd1) begin
            errors++;
            $display("FAIL mid_next_pc got pc_we=%b pc_in=%0d expected 1/1", pc_we, pc_in);
        end
    endtask

    initial begin
        load_prog(8'h00);
        test_reset();
        test_nops();
        test_wrap();
        test_mem_ops();
        test_branches();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
